// File: rtl/mcp_pkg.sv
// Shared types and constants for the clk1->clk2 MCP handshake transfer.
// Combinational declarations only: no latency, no flow control.
package mcp_pkg;

  typedef enum logic {S_IDLE, S_WAIT} src_state_t;
  typedef enum logic {D_IDLE, D_FULL} dst_state_t;

  localparam int MODE_PASS   = 0;
  localparam int MODE_DOUBLE = 1;

  // Destination word is one bit wider so doubling never truncates.
  function automatic int out_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mcp_sync_cell.sv
// STAGES-deep single-bit synchroniser with synchronous active-high reset.
// Latency STAGES clk edges; no flow control.
module mcp_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sff;

  always_ff @(posedge clk) begin
    if (reset) sff <= '0;
    else       sff <= {sff[STAGES-2:0], d};
  end

  assign q = sff[STAGES-1];

endmodule

// File: rtl/mcp_handshake_sync.sv
// clk1->clk2 one-word MCP transfer; dst_valid SYNC_STAGES+1 clk2 edges after req, src_ready stalls until ack returns.
// Optional even parity on the hold register under MCP_HANDSHAKE_SYNC_PARITY_EN.
module mcp_handshake_sync
  import mcp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = MODE_PASS
) (
  input  logic                        clk2,
  input  logic                        reset,
  input  logic                        clk1,
  input  logic                        src_valid,
  input  logic [WIDTH-1:0]            src_data,
  output logic                        src_ready,
  output logic [out_width(WIDTH)-1:0] dst_data,
  output logic                        dst_valid,
  input  logic                        dst_ready,
`ifdef MCP_HANDSHAKE_SYNC_PARITY_EN
  output logic                        busy,
  output logic                        parity_err
`else
  output logic                        busy
`endif
);

  localparam int OW = out_width(WIDTH);
`ifdef MCP_HANDSHAKE_SYNC_PARITY_EN
  localparam int HW = OW + 1;
`else
  localparam int HW = OW;
`endif

  function automatic logic [OW-1:0] xfer_fn(input logic [WIDTH-1:0] d);
    if (MODE == MODE_DOUBLE) return {1'b0, d} + {1'b0, d};
    else                     return {1'b0, d};
  endfunction

  logic [OW-1:0] fval;
  logic [HW-1:0] hold_next;
  logic [HW-1:0] hold;
  logic          req, ack, req_sync, ack_sync;

  assign fval = xfer_fn(src_data);
`ifdef MCP_HANDSHAKE_SYNC_PARITY_EN
  assign hold_next = {^fval, fval};
`else
  assign hold_next = fval;
`endif

  // ---------------- source domain (clk1) ----------------
  src_state_t s_state, s_next;
  logic       s_accept;

  always_ff @(posedge clk1) begin
    if (reset) s_state <= S_IDLE;
    else       s_state <= s_next;
  end

  always_comb begin
    s_next    = s_state;
    s_accept  = 1'b0;
    src_ready = 1'b0;
    busy      = 1'b0;
    case (s_state)
      S_IDLE: begin
        src_ready = 1'b1;
        if (src_valid) begin
          s_accept = 1'b1;
          s_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (ack_sync == req) s_next = S_IDLE;
      end
      default: s_next = S_IDLE;
    endcase
  end

  // hold only changes on accept, so it is stable whenever req != ack
  always_ff @(posedge clk1) begin
    if (reset) begin
      req  <= 1'b0;
      hold <= '0;
    end else if (s_accept) begin
      req  <= ~req;
      hold <= hold_next;
    end
  end

  mcp_sync_cell #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk2),
    .reset (reset),
    .d     (req),
    .q     (req_sync)
  );

  mcp_sync_cell #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk1),
    .reset (reset),
    .d     (ack),
    .q     (ack_sync)
  );

  // ---------------- destination domain (clk2) ----------------
  dst_state_t d_state, d_next;
  logic       capture, retire;

  always_ff @(posedge clk2) begin
    if (reset) d_state <= D_IDLE;
    else       d_state <= d_next;
  end

  always_comb begin
    d_next  = d_state;
    capture = 1'b0;
    retire  = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (req_sync != ack) begin
          capture = 1'b1;
          d_next  = D_FULL;
        end
      end
      D_FULL: begin
        if (dst_ready) begin
          retire = 1'b1;
          d_next = D_IDLE;
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  assign dst_valid = (d_state == D_FULL);

  always_ff @(posedge clk2) begin
    if (reset) begin
      dst_data <= '0;
      ack      <= 1'b0;
    end else begin
      if (capture) dst_data <= hold[OW-1:0];
      if (retire)  ack      <= req_sync;
    end
  end

`ifdef MCP_HANDSHAKE_SYNC_PARITY_EN
  // even parity: a good word reduces to zero across data plus parity bit
  always_ff @(posedge clk2) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= capture & (^hold);
  end
`endif

endmodule

// File: doc/mcp_handshake_sync.md
Name: mcp_handshake_sync

Overview:
- Parametrised clk1→clk2 data-transfer block using the multi-cycle-path (MCP) scheme.
- Source side captures a word into a hold register and sends a toggle request through an N-stage synchroniser.
- Destination side samples the stable hold register, presents it with a valid/ready handshake, and returns a toggle acknowledge.
- Replaces the fixed 8-bit, free-running two-flop path with a flow-controlled, width/depth-parametrised transfer, including optional doubling arithmetic.

Parameters:
- WIDTH, 8, source data width.
- SYNC_STAGES, 2, flops per synchroniser chain; legal range 2..4.
- MODE, 0, 0 = pass-through, 1 = double (data + data).

Ports:
- clk2 input 1: destination clock; block reference clock.
- reset input 1: synchronous, active-high reset, sampled by clk2 (and by clk1 in the source domain).
- clk1 input 1: source clock.
- src_valid input 1: source word offered (clk1).
- src_data input WIDTH: source word (clk1).
- src_ready output 1: source may offer a word (clk1).
- dst_data output WIDTH+1: transferred word (clk2).
- dst_valid output 1: dst_data valid (clk2).
- dst_ready input 1: consumer accepts dst_data (clk2).
- busy output 1: transfer in flight, i.e. source not idle (clk1).

Behaviour:
- Reset:
  - Synchronous, active-high; sampled by flops in both domains.
  - Integrator holds reset for at least SYNC_STAGES+2 cycles of the slower clock.
  - Reset values: src_ready=1, busy=0, dst_valid=0, dst_data=0, req=0, ack=0, hold register=0, all sync flops=0.
- Source FSM (clk1), states S_IDLE and S_WAIT:
  - S_IDLE: src_ready=1. On src_valid=1:
    - hold ← f(src_data);
    - req toggles;
    - go to S_WAIT.
  - S_WAIT: src_ready=0, busy=1; src_valid is ignored. When ack_sync == req, go to S_IDLE.
  - Next accept possible in the clk1 cycle after the return to S_IDLE.
- Arithmetic f():
  - Result width is WIDTH+1.
  - MODE=0: {1'b0, src_data}.
  - MODE=1: src_data + src_data, full WIDTH+1 result, no truncation. Example: 8'hFF → 9'h1FE.
- Hold register:
  - Written only on a source accept.
  - Stable while req ≠ ack. This is the MCP guarantee that makes the multi-bit crossing safe.
- Destination FSM (clk2), states D_IDLE and D_FULL:
  - req is synchronised through SYNC_STAGES flops to req_sync.
  - D_IDLE: when req_sync ≠ ack:
    - dst_data ← hold;
    - dst_valid=1;
    - go to D_FULL.
  - D_FULL: dst_valid and dst_data are held until dst_ready=1 is sampled. On that edge:
    - dst_valid=0;
    - ack ← req_sync;
    - go to D_IDLE.
  - dst_ready=1 while dst_valid=0 has no effect.
- Ack return: ack is synchronised through SYNC_STAGES clk1 flops to ack_sync.
- Latency, from the clk1 accept edge:
  - dst_valid rises SYNC_STAGES+1 clk2 edges after req changes.
  - Round trip to src_ready=1 is an additional 1 clk2 edge plus SYNC_STAGES+1 clk1 edges after dst acceptance.
- Simultaneous events: dst_ready asserted in the same cycle dst_valid rises does not complete the transfer. Acceptance needs dst_valid=1 already registered.
- Backpressure: with dst_ready=0 the source stays in S_WAIT indefinitely. No data is lost or overwritten.
- Reset mid-transfer: both sides return to idle and the in-flight word is discarded. req=ack=0 keeps the toggles consistent, so no spurious dst_valid is produced after reset.
- One word in flight maximum. No FIFO.

Optional Feature:
- Macro: MCP_HANDSHAKE_SYNC_PARITY_EN.
- Defined:
  - hold carries an even-parity bit computed from f(src_data).
  - Destination recomputes parity on capture.
  - Added output parity_err (1 bit, clk2) is a one-cycle pulse on a mismatch at capture.
  - parity_err resets to 0.
  - dst_valid behaviour is unchanged.
- Undefined: no parity bit, no parity_err port. Behaviour is otherwise identical.

Decomposition:
- Package mcp_pkg:
  - typedef enum for source states {S_IDLE, S_WAIT};
  - typedef enum for destination states {D_IDLE, D_FULL};
  - constants MODE_PASS=0 and MODE_DOUBLE=1;
  - localparam function for the output width (WIDTH+1).
- Sub-module mcp_sync_cell:
  - SYNC_STAGES-deep single-bit synchroniser with synchronous active-high reset.
  - Instantiated twice: req into clk2, ack into clk1.

Test Plan:
- Basic pass, MODE=0, WIDTH=8, clk1=clk2, dst_ready=1: send 8'hA5 → dst_data=9'h0A5, one dst_valid pulse SYNC_STAGES+1 edges after req, src_ready back high.
- Double mode, MODE=1: send 8'hFF and then 8'h01 → dst_data 9'h1FE, then 9'h002, in order, no truncation.
- Backpressure, clk1 fast / clk2 slow (3:1 ratio), dst_ready=0 for 20 clk2 cycles, source sends 8'h3C then keeps src_valid=1 → dst_data/dst_valid held at 9'h03C; src_ready=0 and busy=1 throughout; second word only accepted after dst_ready.
- Reset mid-transfer: assert reset while in S_WAIT/D_FULL with 8'h77 in flight → all outputs at reset values, no dst_valid after release, next word 8'h12 delivers 9'h012 correctly.
- Async clocks with random ratio and random dst_ready, 1000 words, SYNC_STAGES=3 → scoreboard matches f(src_data) in order, zero drops or duplicates.
- With MCP_HANDSHAKE_SYNC_PARITY_EN, force one hold bit during flight → parity_err pulses for exactly 1 clk2 cycle at capture.
